// File: rtl/riscv_amo_pkg.sv
// Shared definitions for the data-cache AMO engine: funct5 codes, FSM state
// encoding, SC failure code and the legality check used at request accept.
package riscv_amo_pkg;

    localparam logic [4:0] AMO_ADD  = 5'b00000;
    localparam logic [4:0] AMO_SWAP = 5'b00001;
    localparam logic [4:0] AMO_LR   = 5'b00010;
    localparam logic [4:0] AMO_SC   = 5'b00011;
    localparam logic [4:0] AMO_XOR  = 5'b00100;
    localparam logic [4:0] AMO_OR   = 5'b01000;
    localparam logic [4:0] AMO_AND  = 5'b01100;
    localparam logic [4:0] AMO_MIN  = 5'b10000;
    localparam logic [4:0] AMO_MAX  = 5'b10100;
    localparam logic [4:0] AMO_MINU = 5'b11000;
    localparam logic [4:0] AMO_MAXU = 5'b11100;

    localparam int unsigned SC_FAIL_CODE = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MODIFY,
        ST_WRITE,
        ST_RESP
    } amo_state_e;

    function automatic logic amo_ctrl_legal(input logic [4:0] ctrl, input logic lrsc_en);
        case (ctrl)
            AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
            AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: return 1'b1;
            AMO_LR, AMO_SC:                       return lrsc_en;
            default:                              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_amo_alu.sv
// Combinational AMO compute: new = f(old, rs2). Word ops work on the low 32
// bits only; the upper bits of the result are don't-care for word ops.
module riscv_amo_alu
    import riscv_amo_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [4:0]      ctrl,
    input  logic            dword,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic [XLEN-1:0] new_val
);

    localparam logic [XLEN-1:0] HI_MASK = ~XLEN'(32'hFFFF_FFFF);

    logic            is_dw;
    logic            signed_op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            lt_s;
    logic            lt_u;

    assign is_dw     = (XLEN == 64) && dword;
    assign signed_op = (ctrl == AMO_MIN) || (ctrl == AMO_MAX);

    // Word operands are widened so a single full-width compare gives the
    // 32-bit signed or unsigned ordering.
    always_comb begin
        a = old_val;
        b = rs2_val;
        if (!is_dw) begin
            a = XLEN'(old_val[31:0]);
            b = XLEN'(rs2_val[31:0]);
            if (signed_op && old_val[31]) a = a | HI_MASK;
            if (signed_op && rs2_val[31]) b = b | HI_MASK;
        end
    end

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    always_comb begin
        new_val = a;
        case (ctrl)
            AMO_ADD:          new_val = a + b;
            AMO_SWAP, AMO_SC: new_val = b;
            AMO_XOR:          new_val = a ^ b;
            AMO_OR:           new_val = a | b;
            AMO_AND:          new_val = a & b;
            AMO_MIN:          new_val = lt_s ? a : b;
            AMO_MAX:          new_val = lt_s ? b : a;
            AMO_MINU:         new_val = lt_u ? a : b;
            AMO_MAXU:         new_val = lt_u ? b : a;
            default:          new_val = a;
        endcase
    end

endmodule

// File: rtl/riscv_dcache_amo_unit.sv
// Sequenced AMO engine between LSU and data-cache array (read-modify-write over req/ack).
// LR/SC reservation tracking is built only when RISCV_AMO_LRSC_EN is defined.
//
// state     | meaning
// ST_IDLE   | ready; latch request, route by legality / SC reservation
// ST_READ   | mem_rd held until ack; capture old value (LR ends here)
// ST_MODIFY | register ALU result
// ST_WRITE  | mem_wr held until ack with merged data and byte enables
// ST_RESP   | one-cycle response pulse
module riscv_dcache_amo_unit
    import riscv_amo_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              i_riscv_amo_clk,
    input  logic              i_riscv_amo_rst,
    input  logic              i_riscv_amo_req_valid,
    output logic              o_riscv_amo_req_ready,
    input  logic [4:0]        i_riscv_amo_ctrl,
    input  logic              i_riscv_amo_xlen,
    input  logic [ADDR_W-1:0] i_riscv_amo_addr,
    input  logic [XLEN-1:0]   i_riscv_amo_rs2data,
    output logic              o_riscv_amo_mem_rd,
    output logic              o_riscv_amo_mem_wr,
    output logic [ADDR_W-1:0] o_riscv_amo_mem_addr,
    output logic [XLEN-1:0]   o_riscv_amo_mem_wdata,
    output logic [XLEN/8-1:0] o_riscv_amo_mem_be,
    input  logic [XLEN-1:0]   i_riscv_amo_mem_rdata,
    input  logic              i_riscv_amo_mem_ack,
    input  logic              i_riscv_amo_st_valid,
    input  logic [ADDR_W-1:0] i_riscv_amo_st_addr,
    output logic              o_riscv_amo_rsp_valid,
    output logic [XLEN-1:0]   o_riscv_amo_rsp_data,
    output logic              o_riscv_amo_rsp_err
);

    localparam int                BE_W      = XLEN / 8;
    localparam logic [ADDR_W-1:0] BUS_ALIGN = ~ADDR_W'(BE_W - 1);
    localparam logic [XLEN-1:0]   HI_MASK   = ~XLEN'(32'hFFFF_FFFF);
    localparam logic [BE_W-1:0]   BE_LO     = BE_W'(8'h0F);
    localparam logic [BE_W-1:0]   BE_HI     = BE_W'(8'hF0);
`ifdef RISCV_AMO_LRSC_EN
    localparam logic LRSC_EN = 1'b1;
`else
    localparam logic LRSC_EN = 1'b0;
`endif

    amo_state_e        state_q;
    amo_state_e        state_d;
    logic [4:0]        ctrl_q;
    logic              dw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   rs2_q;
    logic [XLEN-1:0]   data_q;
    logic [XLEN-1:0]   new_q;
    logic              err_q;

    logic              req_dw;
    logic              req_legal;
    logic              sc_ok;
    logic [31:0]       lane_word;
    logic [XLEN-1:0]   lane_old;
    logic [XLEN-1:0]   alu_new;
    logic [XLEN-1:0]   merged_wdata;
    logic [BE_W-1:0]   merged_be;

    assign req_dw    = (XLEN == 64) && i_riscv_amo_xlen;
    assign req_legal = amo_ctrl_legal(i_riscv_amo_ctrl, LRSC_EN);

    // Selected lane of the read data, sign-extended for word accesses.
    always_comb begin
        lane_word = (XLEN == 64 && addr_q[2]) ? i_riscv_amo_mem_rdata[XLEN-1 -: 32]
                                              : i_riscv_amo_mem_rdata[31:0];
        lane_old  = i_riscv_amo_mem_rdata;
        if (!dw_q) begin
            lane_old = XLEN'(lane_word);
            if (lane_word[31]) lane_old = lane_old | HI_MASK;
        end
    end

    riscv_amo_alu #(.XLEN(XLEN)) u_alu (
        .ctrl    (ctrl_q),
        .dword   (dw_q),
        .old_val (data_q),
        .rs2_val (rs2_q),
        .new_val (alu_new)
    );

    always_comb begin
        merged_wdata = dw_q ? new_q : {(XLEN/32){new_q[31:0]}};
        merged_be    = '1;
        if (XLEN == 64 && !dw_q) merged_be = addr_q[2] ? BE_HI : BE_LO;
    end

`ifdef RISCV_AMO_LRSC_EN
    logic              rsv_valid_q;
    logic [ADDR_W-1:0] rsv_addr_q;
    logic              st_kill;
    logic              lr_set;
    logic              sc_take;

    function automatic logic [ADDR_W-1:0] size_align(input logic [ADDR_W-1:0] a, input logic dw);
        return dw ? (a & ~ADDR_W'(7)) : (a & ~ADDR_W'(3));
    endfunction

    // Stores are compared at bus granularity, so any store touching the
    // reserved doubleword kills the reservation.
    assign st_kill = i_riscv_amo_st_valid && rsv_valid_q &&
                     ((i_riscv_amo_st_addr & BUS_ALIGN) == (rsv_addr_q & BUS_ALIGN));
    assign sc_ok   = rsv_valid_q && !st_kill &&
                     (rsv_addr_q == size_align(i_riscv_amo_addr, req_dw));
    assign lr_set  = (state_q == ST_READ) && i_riscv_amo_mem_ack && (ctrl_q == AMO_LR);
    assign sc_take = (state_q == ST_IDLE) && i_riscv_amo_req_valid && (i_riscv_amo_ctrl == AMO_SC);

    always_ff @(posedge i_riscv_amo_clk or posedge i_riscv_amo_rst) begin
        if (i_riscv_amo_rst) begin
            rsv_valid_q <= 1'b0;
            rsv_addr_q  <= '0;
        end else if (sc_take) begin
            rsv_valid_q <= 1'b0;
        end else if (lr_set) begin
            rsv_valid_q <= 1'b1;
            rsv_addr_q  <= size_align(addr_q, dw_q);
        end else if (st_kill) begin
            rsv_valid_q <= 1'b0;
        end
    end
`else
    logic unused_st;
    assign unused_st = ^{i_riscv_amo_st_valid, i_riscv_amo_st_addr};
    assign sc_ok     = 1'b0;
`endif

    always_ff @(posedge i_riscv_amo_clk or posedge i_riscv_amo_rst) begin
        if (i_riscv_amo_rst) state_q <= ST_IDLE;
        else                 state_q <= state_d;
    end

    always_comb begin
        state_d               = state_q;
        o_riscv_amo_req_ready = 1'b0;
        o_riscv_amo_mem_rd    = 1'b0;
        o_riscv_amo_mem_wr    = 1'b0;
        o_riscv_amo_mem_addr  = '0;
        o_riscv_amo_mem_wdata = '0;
        o_riscv_amo_mem_be    = '0;
        o_riscv_amo_rsp_valid = 1'b0;
        o_riscv_amo_rsp_data  = '0;
        o_riscv_amo_rsp_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_riscv_amo_req_ready = 1'b1;
                if (i_riscv_amo_req_valid) begin
                    if (!req_legal)                       state_d = ST_RESP;
                    else if (i_riscv_amo_ctrl == AMO_SC) state_d = sc_ok ? ST_WRITE : ST_RESP;
                    else                                  state_d = ST_READ;
                end
            end
            ST_READ: begin
                o_riscv_amo_mem_rd   = 1'b1;
                o_riscv_amo_mem_addr = addr_q & BUS_ALIGN;
                if (i_riscv_amo_mem_ack) state_d = (ctrl_q == AMO_LR) ? ST_RESP : ST_MODIFY;
            end
            ST_MODIFY: state_d = ST_WRITE;
            ST_WRITE: begin
                o_riscv_amo_mem_wr    = 1'b1;
                o_riscv_amo_mem_addr  = addr_q & BUS_ALIGN;
                o_riscv_amo_mem_wdata = merged_wdata;
                o_riscv_amo_mem_be    = merged_be;
                if (i_riscv_amo_mem_ack) state_d = ST_RESP;
            end
            ST_RESP: begin
                o_riscv_amo_rsp_valid = 1'b1;
                o_riscv_amo_rsp_data  = data_q;
                o_riscv_amo_rsp_err   = err_q;
                state_d               = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // new_q is preloaded with rs2 so a successful SC can go straight to WRITE.
    always_ff @(posedge i_riscv_amo_clk or posedge i_riscv_amo_rst) begin
        if (i_riscv_amo_rst) begin
            ctrl_q <= '0;
            dw_q   <= 1'b0;
            addr_q <= '0;
            rs2_q  <= '0;
            data_q <= '0;
            new_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_riscv_amo_req_valid) begin
                        ctrl_q <= i_riscv_amo_ctrl;
                        dw_q   <= req_dw;
                        addr_q <= i_riscv_amo_addr;
                        rs2_q  <= i_riscv_amo_rs2data;
                        new_q  <= i_riscv_amo_rs2data;
                        err_q  <= !req_legal;
                        data_q <= '0;
                        if (req_legal && i_riscv_amo_ctrl == AMO_SC && !sc_ok)
                            data_q <= XLEN'(SC_FAIL_CODE);
                    end
                end
                ST_READ:   if (i_riscv_amo_mem_ack) data_q <= lane_old;
                ST_MODIFY: new_q <= alu_new;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dcache_amo_unit.sv
// Directed bench for riscv_dcache_amo_unit with a cycle-stepped cache responder.
// LR/SC cases follow RISCV_AMO_LRSC_EN (legal when defined, illegal otherwise).
module tb_riscv_dcache_amo_unit;
    import riscv_amo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  ctrl;
    logic        xlen;
    logic [63:0] addr;
    logic [63:0] rs2;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic        st_valid;
    logic [63:0] st_addr;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_err;

    riscv_dcache_amo_unit #(.XLEN(64), .ADDR_W(64)) dut (
        .i_riscv_amo_clk       (clk),
        .i_riscv_amo_rst       (rst),
        .i_riscv_amo_req_valid (req_valid),
        .o_riscv_amo_req_ready (req_ready),
        .i_riscv_amo_ctrl      (ctrl),
        .i_riscv_amo_xlen      (xlen),
        .i_riscv_amo_addr      (addr),
        .i_riscv_amo_rs2data   (rs2),
        .o_riscv_amo_mem_rd    (mem_rd),
        .o_riscv_amo_mem_wr    (mem_wr),
        .o_riscv_amo_mem_addr  (mem_addr),
        .o_riscv_amo_mem_wdata (mem_wdata),
        .o_riscv_amo_mem_be    (mem_be),
        .i_riscv_amo_mem_rdata (mem_rdata),
        .i_riscv_amo_mem_ack   (mem_ack),
        .i_riscv_amo_st_valid  (st_valid),
        .i_riscv_amo_st_addr   (st_addr),
        .o_riscv_amo_rsp_valid (rsp_valid),
        .o_riscv_amo_rsp_data  (rsp_data),
        .o_riscv_amo_rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Results of the last run_op
    int          r_cyc;
    logic [63:0] r_data;
    logic        r_err;
    int          r_nrd;
    int          r_nwr;
    logic [63:0] r_raddr;
    logic [63:0] r_waddr;
    logic [63:0] r_wdata;
    logic [7:0]  r_be;
    logic        r_busy_ready;
    logic        r_stable;

    task automatic run_op(input logic [4:0] c, input logic dw, input logic [63:0] a,
                          input logic [63:0] d, input logic [63:0] mem_val,
                          input int rd_wait, input int wr_wait, input logic st_at_accept);
        int rd_cnt = 0;
        int wr_cnt = 0;
        r_cyc = -1; r_data = '0; r_err = 1'b0; r_raddr = '0; r_waddr = '0;
        r_wdata = '0; r_be = '0; r_busy_ready = 1'b1; r_stable = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1; ctrl = c; xlen = dw; addr = a; rs2 = d;
        if (st_at_accept) begin st_valid = 1'b1; st_addr = a; end
        for (int cy = 1; cy <= 40; cy++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; st_valid = 1'b0;
            mem_ack = 1'b0; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            if (cy == 1) r_busy_ready = req_ready;
            if (mem_rd) begin
                if (rd_cnt == 0) r_raddr = mem_addr;
                else if (mem_addr !== r_raddr) r_stable = 1'b0;
                rd_cnt++;
                if (rd_cnt > rd_wait) begin mem_ack = 1'b1; mem_rdata = mem_val; end
            end
            if (mem_wr) begin
                if (wr_cnt == 0) begin r_waddr = mem_addr; r_wdata = mem_wdata; r_be = mem_be; end
                else if (mem_addr !== r_waddr || mem_wdata !== r_wdata || mem_be !== r_be) r_stable = 1'b0;
                wr_cnt++;
                if (wr_cnt > wr_wait) mem_ack = 1'b1;
            end
            if (rsp_valid) begin
                r_cyc = cy; r_data = rsp_data; r_err = rsp_err;
                break;
            end
        end
        mem_ack = 1'b0;
        r_nrd = rd_cnt;
        r_nwr = wr_cnt;
    endtask

    typedef struct {
        logic [4:0]  c;
        logic        dw;
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] mem;
        int          rdw;
        int          wrw;
        logic [63:0] wdata;
        logic [7:0]  be;
        logic [63:0] rsp;
        int          cyc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic bad_after;

        vecs[0] = '{AMO_ADD,  1'b1, 64'h1000, 64'h1, 64'h0000_0000_FFFF_FFFF, 0, 0,
                    64'h0000_0001_0000_0000, 8'hFF, 64'h0000_0000_FFFF_FFFF, 4};
        vecs[1] = '{AMO_MAX,  1'b0, 64'h1004, 64'h5, 64'h8000_0000_1234_5678, 0, 0,
                    64'h0000_0005_0000_0005, 8'hF0, 64'hFFFF_FFFF_8000_0000, 4};
        vecs[2] = '{AMO_MINU, 1'b0, 64'h2000, 64'h2, 64'h1111_1111_FFFF_FFFF, 3, 3,
                    64'h0000_0002_0000_0002, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 10};
        vecs[3] = '{AMO_XOR,  1'b0, 64'h2008, 64'hFFFF_0000, 64'hAAAA_AAAA_0F0F_0F0F, 0, 0,
                    64'hF0F0_0F0F_F0F0_0F0F, 8'h0F, 64'h0000_0000_0F0F_0F0F, 4};
        vecs[4] = '{AMO_SWAP, 1'b1, 64'h2010, 64'h123, 64'hDEAD_BEEF_0000_0001, 1, 0,
                    64'h0000_0000_0000_0123, 8'hFF, 64'hDEAD_BEEF_0000_0001, 5};
        vecs[5] = '{AMO_MIN,  1'b1, 64'h2018, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1,
                    64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 5};
        vecs[6] = '{AMO_MAXU, 1'b0, 64'h2024, 64'h5, 64'h8000_0000_0000_0007, 0, 0,
                    64'h8000_0000_8000_0000, 8'hF0, 64'hFFFF_FFFF_8000_0000, 4};
        vecs[7] = '{AMO_AND,  1'b1, 64'h2028, 64'h0FF0_0FF0_0FF0_0FF0, 64'hFF00_FF00_FF00_FF00, 0, 0,
                    64'h0F00_0F00_0F00_0F00, 8'hFF, 64'hFF00_FF00_FF00_FF00, 4};
        vecs[8] = '{AMO_OR,   1'b0, 64'h2030, 64'hFFFF_FFFF_0000_000F, 64'h1234_5678_0000_00F0, 0, 0,
                    64'h0000_00FF_0000_00FF, 8'h0F, 64'h0000_0000_0000_00F0, 4};
        vecs[9] = '{AMO_ADD,  1'b0, 64'h2034, 64'h1, 64'hFFFF_FFFF_0000_0000, 0, 0,
                    64'h0000_0000_0000_0000, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF, 4};

        rst = 1'b1; req_valid = 1'b0; ctrl = '0; xlen = 1'b0; addr = '0; rs2 = '0;
        mem_rdata = '0; mem_ack = 1'b0; st_valid = 1'b0; st_addr = '0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].c, vecs[i].dw, vecs[i].a, vecs[i].d, vecs[i].mem, vecs[i].rdw, vecs[i].wrw, 1'b0);
            chk($sformatf("v%0d_cyc", i), r_cyc, vecs[i].cyc);
            chk($sformatf("v%0d_rsp", i), r_data, vecs[i].rsp);
            chk($sformatf("v%0d_err", i), r_err, 0);
            chk($sformatf("v%0d_wdata", i), r_wdata, vecs[i].wdata);
            chk($sformatf("v%0d_be", i), r_be, vecs[i].be);
            chk($sformatf("v%0d_raddr", i), r_raddr, vecs[i].a & ~64'h7);
            chk($sformatf("v%0d_waddr", i), r_waddr, vecs[i].a & ~64'h7);
            chk($sformatf("v%0d_nrd", i), r_nrd, vecs[i].rdw + 1);
            chk($sformatf("v%0d_nwr", i), r_nwr, vecs[i].wrw + 1);
            chk($sformatf("v%0d_busy", i), r_busy_ready, 0);
            chk($sformatf("v%0d_stable", i), r_stable, 1);
        end

        run_op(5'b11111, 1'b1, 64'h3000, 64'h7, 64'h0, 0, 0, 1'b0);
        chk("ill_cyc", r_cyc, 1);
        chk("ill_err", r_err, 1);
        chk("ill_data", r_data, 0);
        chk("ill_nrd", r_nrd, 0);
        chk("ill_nwr", r_nwr, 0);

`ifdef RISCV_AMO_LRSC_EN
        run_op(AMO_LR, 1'b1, 64'h3000, 64'h0, 64'h0000_0000_0000_0055, 0, 0, 1'b0);
        chk("lr_cyc", r_cyc, 2);
        chk("lr_data", r_data, 64'h55);
        chk("lr_nwr", r_nwr, 0);
        run_op(AMO_SC, 1'b1, 64'h3000, 64'hAB, 64'h0, 0, 0, 1'b0);
        chk("sc_ok_data", r_data, 0);
        chk("sc_ok_err", r_err, 0);
        chk("sc_ok_nrd", r_nrd, 0);
        chk("sc_ok_nwr", r_nwr, 1);
        chk("sc_ok_wdata", r_wdata, 64'hAB);
        chk("sc_ok_be", r_be, 8'hFF);
        chk("sc_ok_cyc", r_cyc, 2);
        run_op(AMO_SC, 1'b1, 64'h3000, 64'hCD, 64'h0, 0, 0, 1'b0);
        chk("sc_norsv_data", r_data, 1);
        chk("sc_norsv_nwr", r_nwr, 0);
        run_op(AMO_LR, 1'b1, 64'h3000, 64'h0, 64'h55, 0, 0, 1'b0);
        @(posedge clk); #1 st_valid = 1'b1; st_addr = 64'h3000;
        @(posedge clk); #1 st_valid = 1'b0;
        run_op(AMO_SC, 1'b1, 64'h3000, 64'hAB, 64'h0, 0, 0, 1'b0);
        chk("sc_kill_data", r_data, 1);
        chk("sc_kill_nwr", r_nwr, 0);
        chk("sc_kill_cyc", r_cyc, 1);
        run_op(AMO_LR, 1'b0, 64'h3004, 64'h0, 64'h8000_0001_0000_0000, 0, 0, 1'b0);
        chk("lrw_data", r_data, 64'hFFFF_FFFF_8000_0001);
        run_op(AMO_SC, 1'b0, 64'h3004, 64'hAB, 64'h0, 0, 0, 1'b1);
        chk("sc_coinc_data", r_data, 1);
        chk("sc_coinc_nwr", r_nwr, 0);
`else
        run_op(AMO_LR, 1'b1, 64'h3000, 64'h0, 64'h55, 0, 0, 1'b0);
        chk("lr_ill_err", r_err, 1);
        chk("lr_ill_cyc", r_cyc, 1);
        chk("lr_ill_nrd", r_nrd, 0);
        run_op(AMO_SC, 1'b1, 64'h3000, 64'hAB, 64'h0, 0, 0, 1'b0);
        chk("sc_ill_err", r_err, 1);
        chk("sc_ill_data", r_data, 0);
        chk("sc_ill_nwr", r_nwr, 0);
`endif

        // Abort during a stalled write
        @(posedge clk); #1;
        req_valid = 1'b1; ctrl = AMO_ADD; xlen = 1'b1; addr = 64'h4000; rs2 = 64'h1;
        seen = 1'b0;
        for (int cy = 1; cy <= 20 && !seen; cy++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; mem_ack = 1'b0;
            if (mem_rd) begin mem_ack = 1'b1; mem_rdata = 64'h5; end
            if (mem_wr) seen = 1'b1;
        end
        chk("abort_reached_wr", seen, 1);
        @(posedge clk); #1;
        chk("abort_wr_held", mem_wr, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_wr_drop", mem_wr, 0);
        chk("abort_rd_low", mem_rd, 0);
        @(posedge clk); #1 rst = 1'b0;
        chk("abort_ready", req_ready, 1);
        bad_after = 1'b0;
        for (int cy = 0; cy < 6; cy++) begin
            @(posedge clk); #1;
            if (rsp_valid || mem_wr || mem_rd) bad_after = 1'b1;
        end
        chk("abort_quiet", bad_after, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
